// File: rtl/bp_addr_xlate_stage_pkg.sv
// Shared width constants and types for the bare-mode address translation stage.
// Entry struct is what the output buffer stores per accepted request.
package bp_addr_xlate_stage_pkg;

    localparam int unsigned bp_eaddr_width_gp       = 64;
    localparam int unsigned bp_vaddr_width_gp       = 39;
    localparam int unsigned bp_paddr_width_gp       = 22;
    localparam int unsigned bp_page_offset_width_gp = 12;

    typedef enum logic [1:0] {
        e_xlate_fetch = 2'b00,
        e_xlate_load  = 2'b01,
        e_xlate_store = 2'b10
    } bp_xlate_kind_e;

    typedef enum logic [1:0] {
        e_cause_none       = 2'b00,
        e_cause_page       = 2'b01,
        e_cause_access     = 2'b10,
        e_cause_misaligned = 2'b11
    } bp_xlate_cause_e;

    typedef struct packed {
        logic [bp_paddr_width_gp-1:0] paddr;
        bp_xlate_kind_e               kind;
        logic                         fault;
        bp_xlate_cause_e              cause;
    } bp_xlate_entry_s;

endpackage

// File: rtl/bp_addr_xlate_stage_if.sv
// Request/response bundle between requesters, the translation stage and the
// memory-side consumer. The stage uses the slave modport.
interface bp_addr_xlate_stage_if #(
    parameter int unsigned eaddr_width_p       = 64,
    parameter int unsigned paddr_width_p       = 22,
    parameter int unsigned page_offset_width_p = 12
);

    logic                           v_i;
    logic                           ready_o;
    logic [eaddr_width_p-1:0]       eaddr_i;
    logic [1:0]                     kind_i;
    logic [1:0]                     size_i;
    logic                           v_o;
    logic                           yumi_i;
    logic [paddr_width_p-1:0]       paddr_o;
    logic [page_offset_width_p-1:0] page_offset_o;
    logic [1:0]                     kind_o;
    logic                           fault_o;
    logic [1:0]                     cause_o;

    modport slave (
        input  v_i, eaddr_i, kind_i, size_i, yumi_i,
        output ready_o, v_o, paddr_o, page_offset_o, kind_o, fault_o, cause_o
    );

    modport master (
        output v_i, eaddr_i, kind_i, size_i, yumi_i,
        input  ready_o, v_o, paddr_o, page_offset_o, kind_o, fault_o, cause_o
    );

endinterface

// File: rtl/bp_addr_xlate_stage_addr_check.sv
// Combinational SV39 canonicality, physical range and alignment check.
// Produces the buffer entry for an incoming effective address.
module bp_addr_check
    import bp_addr_xlate_stage_pkg::*;
#(
    parameter int unsigned eaddr_width_p = bp_eaddr_width_gp,
    parameter int unsigned vaddr_width_p = bp_vaddr_width_gp,
    parameter int unsigned paddr_width_p = bp_paddr_width_gp
) (
    input  logic [eaddr_width_p-1:0] eaddr_i,
    input  logic [1:0]               kind_i,
    input  logic [1:0]               size_i,
    output bp_xlate_entry_s          entry_o
);

    logic [eaddr_width_p-vaddr_width_p:0] upper;
    logic                                 page_fault;
    logic                                 access_fault;
    logic                                 misaligned;
    logic [1:0]                           sz;
    logic [2:0]                           mask;
    bp_xlate_kind_e                       kind;
    bp_xlate_cause_e                      cause;

    // Sign-extension region includes bit vaddr_width_p-1 itself.
    assign upper        = eaddr_i[eaddr_width_p-1:vaddr_width_p-1];
    assign page_fault   = !((upper == '0) || (upper == '1));
    assign access_fault = |eaddr_i[vaddr_width_p-1:paddr_width_p];

    always_comb begin
        kind = e_xlate_load;
        sz   = size_i;
        case (kind_i)
            2'b00: begin
                kind = e_xlate_fetch;
                sz   = 2'd2;
            end
            2'b10:   kind = e_xlate_store;
            default: kind = e_xlate_load;
        endcase
    end

    assign mask       = 3'((4'd1 << sz) - 4'd1);
    assign misaligned = |(eaddr_i[2:0] & mask);

    always_comb begin
        if (page_fault)        cause = e_cause_page;
        else if (access_fault) cause = e_cause_access;
        else if (misaligned)   cause = e_cause_misaligned;
        else                   cause = e_cause_none;
    end

    always_comb begin
        entry_o.kind  = kind;
        entry_o.cause = cause;
        entry_o.fault = (cause != e_cause_none);
        entry_o.paddr = entry_o.fault ? '0 : eaddr_i[paddr_width_p-1:0];
    end

endmodule

// File: rtl/bp_addr_xlate_stage.sv
// Bare-mode address translation stage: checks each request and queues the
// result in a 2-entry circular buffer toward the memory-side consumer.
module bp_addr_xlate_stage
    import bp_addr_xlate_stage_pkg::*;
#(
    parameter int unsigned eaddr_width_p       = bp_eaddr_width_gp,
    parameter int unsigned vaddr_width_p       = bp_vaddr_width_gp,
    parameter int unsigned paddr_width_p       = bp_paddr_width_gp,
    parameter int unsigned page_offset_width_p = bp_page_offset_width_gp
) (
    input logic                    clk_i,
    input logic                    reset_i,
    input logic                    flush_i,
    bp_addr_xlate_stage_if.slave   bus
);

    bp_xlate_entry_s check_entry;
    bp_xlate_entry_s head;
    bp_xlate_entry_s mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic            enq;
    logic            deq;

    bp_addr_check #(
        .eaddr_width_p (eaddr_width_p),
        .vaddr_width_p (vaddr_width_p),
        .paddr_width_p (paddr_width_p)
    ) u_check (
        .eaddr_i (bus.eaddr_i),
        .kind_i  (bus.kind_i),
        .size_i  (bus.size_i),
        .entry_o (check_entry)
    );

    // ready depends only on registered count (and reset), never on yumi_i.
    assign bus.ready_o = ~reset_i & (count != 2'd2);
    assign bus.v_o     = (count != 2'd0);
    assign enq         = bus.v_i & bus.ready_o;
    assign deq         = bus.yumi_i & bus.v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + 2'(enq) - 2'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !flush_i) mem[wr_ptr] <= check_entry;
    end

    // Outputs forced to zero when empty so stale storage never shows.
    assign head              = bus.v_o ? mem[rd_ptr] : '0;
    assign bus.paddr_o       = head.paddr;
    assign bus.page_offset_o = head.paddr[page_offset_width_p-1:0];
    assign bus.kind_o        = head.kind;
    assign bus.fault_o       = head.fault;
    assign bus.cause_o       = head.cause;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.yumi_i |-> bus.v_o);

endmodule

// File: tb/tb_bp_addr_xlate_stage.sv
// Directed plus randomized bench for bp_addr_xlate_stage against a queue-based
// reference model computed from the address rules with plain arithmetic.
module tb_bp_addr_xlate_stage;

    typedef struct {
        logic [21:0] paddr;
        logic [1:0]  kind;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_i;
    logic flush_i;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t mq[$];

    bp_addr_xlate_stage_if #(
        .eaddr_width_p       (64),
        .paddr_width_p       (22),
        .page_offset_width_p (12)
    ) bus ();

    bp_addr_xlate_stage #(
        .eaddr_width_p       (64),
        .vaddr_width_p       (39),
        .paddr_width_p       (22),
        .page_offset_width_p (12)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t ref_xlate(logic [63:0] ea, logic [1:0] k, logic [1:0] sz);
        exp_t        r;
        logic [63:0] hi;
        logic [63:0] mid;
        logic [63:0] bytes;
        hi    = ea >> 38;
        mid   = (ea >> 22) % 64'd131072;
        bytes = (k == 2'd0) ? 64'd4 : (64'd1 << sz);
        r.kind = (k == 2'd3) ? 2'd1 : k;
        if (hi != 64'd0 && hi != 64'h3FF_FFFF) r.cause = 2'd1;
        else if (mid != 64'd0)                 r.cause = 2'd2;
        else if (ea % bytes != 64'd0)          r.cause = 2'd3;
        else                                   r.cause = 2'd0;
        r.fault = (r.cause != 2'd0);
        r.paddr = r.fault ? 22'd0 : 22'(ea % 64'd4194304);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("v_o", 64'(bus.v_o), 64'(mq.size() > 0));
        chk("ready_o", 64'(bus.ready_o), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("paddr_o", 64'(bus.paddr_o), 64'(mq[0].paddr));
            chk("page_offset_o", 64'(bus.page_offset_o), 64'(mq[0].paddr % 22'd4096));
            chk("kind_o", 64'(bus.kind_o), 64'(mq[0].kind));
            chk("fault_o", 64'(bus.fault_o), 64'(mq[0].fault));
            chk("cause_o", 64'(bus.cause_o), 64'(mq[0].cause));
        end
    endtask

    // Called at a negedge: drive, let one posedge pass, update model, check at next negedge.
    task automatic step(input logic v, input logic [63:0] ea, input logic [1:0] k,
                        input logic [1:0] sz, input logic y, input logic f);
        logic acc;
        logic dq;
        dq          = y && (mq.size() > 0);
        acc         = v && (mq.size() < 2);
        bus.v_i     = v;
        bus.eaddr_i = ea;
        bus.kind_i  = k;
        bus.size_i  = sz;
        bus.yumi_i  = dq;
        flush_i     = f;
        @(posedge clk_i);
        if (f) mq.delete();
        else begin
            if (dq) void'(mq.pop_front());
            if (acc) mq.push_back(ref_xlate(ea, k, sz));
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] ea;
        logic [63:0] r64;
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        bus.v_i     = 1'b0;
        bus.eaddr_i = '0;
        bus.kind_i  = 2'd0;
        bus.size_i  = 2'd0;
        bus.yumi_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset_v_o", 64'(bus.v_o), 64'd0);
        chk("reset_ready_o", 64'(bus.ready_o), 64'd0);
        chk("reset_paddr_o", 64'(bus.paddr_o), 64'd0);
        chk("reset_page_offset_o", 64'(bus.page_offset_o), 64'd0);
        chk("reset_kind_o", 64'(bus.kind_o), 64'd0);
        chk("reset_fault_o", 64'(bus.fault_o), 64'd0);
        chk("reset_cause_o", 64'(bus.cause_o), 64'd0);
        reset_i = 1'b0;
        #1;
        chk("post_reset_ready_o", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);

        // Basic load, latency 1
        step(1'b1, 64'h0000_0000_0001_0004, 2'd1, 2'd2, 1'b0, 1'b0);
        chk("t1_v_o", 64'(bus.v_o), 64'd1);
        chk("t1_paddr", 64'(bus.paddr_o), 64'h10004);
        chk("t1_page_offset", 64'(bus.page_offset_o), 64'h004);
        chk("t1_cause", 64'(bus.cause_o), 64'd0);
        step(1'b0, 64'd0, 2'd1, 2'd0, 1'b1, 1'b0);

        // Access fault vs page fault
        step(1'b1, 64'hFFFF_FFC0_0000_0000, 2'd1, 2'd2, 1'b0, 1'b0);
        chk("t2_access_cause", 64'(bus.cause_o), 64'd2);
        chk("t2_access_paddr", 64'(bus.paddr_o), 64'd0);
        step(1'b1, 64'h0000_0040_0000_0000, 2'd1, 2'd2, 1'b1, 1'b0);
        chk("t2_page_cause", 64'(bus.cause_o), 64'd1);
        chk("t2_page_fault", 64'(bus.fault_o), 64'd1);

        // Fetch alignment forced to 4B; priority page over misaligned
        step(1'b1, 64'h102, 2'd0, 2'd0, 1'b1, 1'b0);
        chk("t3_fetch_cause", 64'(bus.cause_o), 64'd3);
        chk("t3_fetch_kind", 64'(bus.kind_o), 64'd0);
        step(1'b1, 64'h8000_0000_0000_0002, 2'd1, 2'd3, 1'b1, 1'b0);
        chk("t3_prio_cause", 64'(bus.cause_o), 64'd1);
        step(1'b0, 64'd0, 2'd1, 2'd0, 1'b1, 1'b0);

        // Backpressure: third request held, then drained in order
        step(1'b1, 64'h100, 2'd1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 64'h200, 2'd2, 2'd2, 1'b0, 1'b0);
        chk("t4_full_ready", 64'(bus.ready_o), 64'd0);
        step(1'b1, 64'h300, 2'd3, 2'd2, 1'b0, 1'b0);
        chk("t4_held_head_A", 64'(bus.paddr_o), 64'h100);
        step(1'b1, 64'h300, 2'd3, 2'd2, 1'b1, 1'b0);
        chk("t4_head_B", 64'(bus.paddr_o), 64'h200);
        chk("t4_reopen_ready", 64'(bus.ready_o), 64'd1);
        step(1'b1, 64'h300, 2'd3, 2'd2, 1'b1, 1'b0);
        chk("t4_head_C", 64'(bus.paddr_o), 64'h300);
        chk("t4_reserved_kind", 64'(bus.kind_o), 64'd1);
        step(1'b0, 64'd0, 2'd1, 2'd0, 1'b1, 1'b0);

        // Flush with concurrent request
        step(1'b1, 64'h400, 2'd1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 64'h500, 2'd1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 64'h600, 2'd1, 2'd2, 1'b0, 1'b1);
        chk("t5_flush_v_o", 64'(bus.v_o), 64'd0);
        idle();

        // Async reset mid-stream
        step(1'b1, 64'h700, 2'd1, 2'd2, 1'b0, 1'b0);
        flush_i = 1'b0;
        bus.v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6_reset_v_o", 64'(bus.v_o), 64'd0);
        chk("t6_reset_ready_o", 64'(bus.ready_o), 64'd0);
        chk("t6_reset_paddr_o", 64'(bus.paddr_o), 64'd0);
        mq.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("t6_release_ready_o", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);
        step(1'b1, 64'h804, 2'd2, 2'd2, 1'b0, 1'b0);
        chk("t6_latency1_v_o", 64'(bus.v_o), 64'd1);
        chk("t6_latency1_paddr", 64'(bus.paddr_o), 64'h804);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       ea = r64 & 64'h3F_FFFF;
                1:       ea = {26'h3FF_FFFF, r64[37:0]};
                2:       ea = r64;
                default: ea = r64 & 64'h7F_FFFF_FFFF;
            endcase
            step(1'($urandom_range(0, 3) != 0), ea, 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
